door_plant: RTL
===============

Name: door_plant

Overview:
Synthesizable model of the garage door driven by the motor controller: the other end of the motor_up/motor_dn ↔ up_limit/dn_limit interface.
- Integrates the motor commands into a door position.
- Generates the limit switches from that position.
- Detects illegal drive (both directions at once, sustained drive into a limit) as a sticky fault.
- Closes the loop in the motor bench so the controller runs against a realistic plant instead of hand-driven limits.

Parameters:
TRAVEL, 4, full-travel position count; pos TRAVEL = fully up, 0 = fully down
STEP_DIV, 2, clk cycles per position step while moving (≥1)
POS_W, 3, width of pos; must hold TRAVEL
OVR_LIMIT, 4, consecutive cycles of drive into a reached limit before overdrive fault
INIT_UP, 1, reset position: 1 → TRAVEL (door up), 0 → 0 (door down)

Ports:
clk  in  1  clock; all state on posedge
rst_n  in  1  reset; asynchronous, active-low
motor_up  in  1  drive-up command from controller
motor_dn  in  1  drive-down command from controller
obstruct  in  1  door stalled; steps suppressed while high
fault_clr  in  1  clears sticky fault
up_limit  out  1  pos == TRAVEL
dn_limit  out  1  pos == 0
pos  out  POS_W  current door position
moving  out  1  state is MOVING_UP or MOVING_DN
fault  out  1  state is FAULT
fault_code  out  2  00 none, 01 both commands, 10 overdrive; held while in FAULT

Behaviour:
- Reset values:
  - pos = INIT_UP ? TRAVEL : 0, so up_limit=INIT_UP and dn_limit=~INIT_UP.
  - state IDLE; moving=0, fault=0, fault_code=00; prescaler cnt=0; ovr_cnt=0.
  - rst_n low mid-move aborts immediately to these values.
- Output timing: all outputs are decoded from registers only; no combinational path from inputs.
- Command decode per cycle: up = motor_up&~motor_dn; dn = motor_dn&~motor_up; both = motor_up&motor_dn.
- Priority at each edge, highest first: both → FAULT (code 01) from any non-FAULT state; overdrive → FAULT (code 10); then the normal transitions below.
- IDLE:
  - up & pos<TRAVEL → MOVING_UP.
  - dn & pos>0 → MOVING_DN.
  - Otherwise stay.
- MOVING_UP / MOVING_DN:
  - cnt increments each cycle while the command holds and obstruct=0.
  - When cnt==STEP_DIV-1, pos ±1 and cnt=0.
  - The step that reaches the limit also transitions to IDLE.
  - Command dropped → IDLE, cnt=0, pos unchanged (partial step discarded).
  - Opposite command → opposite MOVING state, cnt=0.
  - obstruct=1 holds both cnt and pos; the state is kept.
- Latency: command first sampled at edge k → state change at edge k; first pos change at edge k+STEP_DIV; full travel takes TRAVEL*STEP_DIV edges after k.
- Overdrive:
  - ovr_cnt increments each cycle with (up & pos==TRAVEL) or (dn & pos==0), saturating.
  - ovr_cnt resets to 0 on any other cycle.
  - Reaching OVR_LIMIT → FAULT code 10.
  - The cycle in which a limit is reached does not count.
- FAULT:
  - pos frozen, moving=0.
  - Exits to IDLE, cnt=0, ovr_cnt=0, code=00 at the edge where fault_clr=1 and both=0.
  - fault_clr together with both=1 stays in FAULT with code 01.
- pos never leaves [0, TRAVEL]; no wrap-around.

Decomposition:
- Package door_pkg:
  - state enum {IDLE, MOVING_UP, MOVING_DN, FAULT};
  - fault code constants FLT_NONE=2'b00, FLT_BOTH=2'b01, FLT_OVR=2'b10.
- Sub-module door_step_prescaler (clk, rst_n, run, clr, step): the STEP_DIV divider.
  - run = moving & ~obstruct; clr on direction change or idle.
  - Parameter STEP_DIV.
- FSM, position register and overdrive counter live in door_plant.

Test Plan:
1. Reset with INIT_UP=1, then motor_dn=1 held → pos 4,3,2,1,0 every 2 cycles; up_limit drops at first step, dn_limit=1 at pos 0, state IDLE; motor_dn dropped within 3 cycles → fault stays 0.
2. From pos 0, motor_up held → pos reaches 4 after 8 cycles, up_limit=1, moving=0; keep motor_up 4 more cycles → fault=1, fault_code=10; fault_clr with motor_up=0 → IDLE, code 00.
3. motor_up=motor_dn=1 for one cycle mid-travel → fault=1, code 01 next edge, pos frozen; fault_clr while both still 1 → remains FAULT.
4. Moving down at pos 2, obstruct=1 for 5 cycles → pos stays 2, moving=1; release → next step 2 cycles later.
5. Moving up at pos 1 with cnt=1, switch to motor_dn → MOVING_DN, cnt cleared, pos 0 two cycles later (no partial step).
6. rst_n pulsed low mid-travel at pos 2 → pos=4, up_limit=1, all flags 0 asynchronously; closed loop with motor controller completes a down/up cycle without fault.

Source files
------------

// File: rtl/door_pkg.sv
// Shared types and constants for the garage door plant model.
package door_pkg;

   localparam int unsigned FLT_W = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVING_UP = 2'd1,
      MOVING_DN = 2'd2,
      FAULT     = 2'd3
   } door_state_e;

   localparam logic [FLT_W-1:0] FLT_NONE = 2'b00;
   localparam logic [FLT_W-1:0] FLT_BOTH = 2'b01;
   localparam logic [FLT_W-1:0] FLT_OVR  = 2'b10;

endpackage

// File: rtl/door_step_prescaler.sv
// Divides the clock by STEP_DIV while the door is driven; step pulses on the last count.
module door_step_prescaler #(
   parameter int unsigned STEP_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic step
);

   localparam int unsigned     CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign step = run & (cnt == CNT_LAST);

   // Neither run nor clr (obstructed) holds the partial count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= step ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/door_plant.sv
// Garage door plant: integrates motor commands into a position, generates limit
// switches and latches illegal-drive faults.
module door_plant
   import door_pkg::*;
#(
   parameter int unsigned TRAVEL    = 4,
   parameter int unsigned STEP_DIV  = 2,
   parameter int unsigned POS_W     = 3,
   parameter int unsigned OVR_LIMIT = 4,
   parameter int unsigned INIT_UP   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             motor_up,
   input  logic             motor_dn,
   input  logic             obstruct,
   input  logic             fault_clr,
   output logic             up_limit,
   output logic             dn_limit,
   output logic [POS_W-1:0] pos,
   output logic             moving,
   output logic             fault,
   output logic [FLT_W-1:0] fault_code
);

   localparam int unsigned      OVR_W   = $clog2(OVR_LIMIT + 1);
   localparam logic [OVR_W-1:0] OVR_MAX = OVR_W'(OVR_LIMIT);
   localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL);
   localparam logic [POS_W-1:0] POS_RST = (INIT_UP != 0) ? POS_W'(TRAVEL) : '0;

   door_state_e      state, state_nxt;
   logic [POS_W-1:0] pos_nxt;
   logic [OVR_W-1:0] ovr_cnt, ovr_nxt;
   logic [FLT_W-1:0] code, code_nxt;

   logic up, dn, both, at_top, at_bot, fwd, ovr_hit, step;

   assign up     = motor_up & ~motor_dn;
   assign dn     = motor_dn & ~motor_up;
   assign both   = motor_up & motor_dn;
   assign at_top = (pos == POS_TOP);
   assign at_bot = (pos == '0);

   // Command still matches the current direction of travel.
   assign fwd     = ((state == MOVING_UP) & up) | ((state == MOVING_DN) & dn);
   assign ovr_hit = (state != FAULT) & ((up & at_top) | (dn & at_bot));
   assign ovr_nxt = !ovr_hit ? '0 : (ovr_cnt == OVR_MAX) ? OVR_MAX : ovr_cnt + OVR_W'(1);

   door_step_prescaler #(
      .STEP_DIV (STEP_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (fwd & ~obstruct),
      .clr   (~fwd),
      .step  (step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pos     <= POS_RST;
         ovr_cnt <= '0;
         code    <= FLT_NONE;
      end else begin
         state   <= state_nxt;
         pos     <= pos_nxt;
         ovr_cnt <= ovr_nxt;
         code    <= code_nxt;
      end
   end

   // Priority: both commands, then overdrive, then normal travel.
   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      code_nxt  = code;
      if (state == FAULT) begin
         if (fault_clr) begin
            if (both) begin
               code_nxt = FLT_BOTH;
            end else begin
               state_nxt = IDLE;
               code_nxt  = FLT_NONE;
            end
         end
      end else if (both) begin
         state_nxt = FAULT;
         code_nxt  = FLT_BOTH;
      end else if (ovr_nxt == OVR_MAX) begin
         state_nxt = FAULT;
         code_nxt  = FLT_OVR;
      end else begin
         case (state)
            IDLE: begin
               if (up && !at_top)      state_nxt = MOVING_UP;
               else if (dn && !at_bot) state_nxt = MOVING_DN;
            end
            MOVING_UP: begin
               if (up) begin
                  if (step) begin
                     pos_nxt = pos + POS_W'(1);
                     if (pos + POS_W'(1) == POS_TOP) state_nxt = IDLE;
                  end
               end else if (dn) begin
                  state_nxt = at_bot ? IDLE : MOVING_DN;
               end else begin
                  state_nxt = IDLE;
               end
            end
            MOVING_DN: begin
               if (dn) begin
                  if (step) begin
                     pos_nxt = pos - POS_W'(1);
                     if (pos == POS_W'(1)) state_nxt = IDLE;
                  end
               end else if (up) begin
                  state_nxt = at_top ? IDLE : MOVING_UP;
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      moving     = (state == MOVING_UP) || (state == MOVING_DN);
      fault      = (state == FAULT);
      fault_code = code;
      up_limit   = at_top;
      dn_limit   = at_bot;
   end

endmodule
